inst_encoder: RTL

- Streaming RV32 instruction encoder: accepts decoded fields (opcode class, registers, funct bits, 32-bit immediate) and emits the packed 32-bit instruction word.
- Inverse of the pipeline's immediate-generation/decode path. Used by the boot/self-test loader to build instruction memory images on chip.
- Two-stage valid/ready pipeline with backpressure, immediate range/alignment checking and saturating statistics counters.

---
 rtl/inst_enc_pkg.sv | 45 ++++
 rtl/inst_encoder_imm_pack.sv | 75 +++++++
 rtl/inst_encoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/inst_enc_pkg.sv
// ---------------------------------------------------------------------------
// inst_enc_pkg
// Purpose : Shared types and constants for the RV32 instruction encoder.
//           Holds the instruction format enum, the opcode[6:2] values that
//           select a non-R format, and the opcode-to-format mapping helper.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package inst_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U
  } fmt_e;

  // Opcode bits [6:2]; bits [1:0] of every RV32 base opcode are 2'b11.
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] JALR   = 5'b11001;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] FLOAD  = 5'b00001;
  localparam logic [4:0] STORE  = 5'b01000;
  localparam logic [4:0] FSTORE = 5'b01001;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] AUIPC  = 5'b00101;
  localparam logic [4:0] LUI    = 5'b01101;

  // Any opcode not listed here is treated as R-type.
  function automatic fmt_e op5_to_fmt(input logic [4:0] op5);
    fmt_e fmt;
    case (op5)
      OP_IMM, JALR, LOAD, FLOAD: fmt = FMT_I;
      STORE, FSTORE:             fmt = FMT_S;
      BRANCH:                    fmt = FMT_B;
      JAL:                       fmt = FMT_J;
      AUIPC, LUI:                fmt = FMT_U;
      default:                   fmt = FMT_R;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// ---------------------------------------------------------------------------
// imm_pack
// Purpose : Combinational packer. Scatters the decoded fields and immediate
//           into the RV32 instruction word for the given format and flags
//           immediates that do not fit (or are misaligned) for that format.
// Ports   : fmt_i     - instruction format
//           op5_i     - opcode bits [6:2]
//           rd_i, rs1_i, rs2_i, funct3_i, funct7_i - register/funct fields
//           imm_i     - sign-extended byte-offset immediate
//           inst_o    - packed instruction word
//           err_o     - immediate out of range / misaligned
// ---------------------------------------------------------------------------
module imm_pack
  import inst_enc_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [4:0]  op5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        err_o
);

  logic [6:0] opcode;

  // An immediate fits in N signed bits when every bit from N-1 upward
  // matches the sign, i.e. the upper slice is all ones or all zeros.
  logic fits12;
  logic fits13;
  logic fits21;

  assign opcode = {op5_i, 2'b11};
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Erroneous immediates are still packed (truncated); err_o travels with
  // the word so the loader can decide what to do.
  always_comb begin
    inst_o = '0;
    err_o  = 1'b0;
    case (fmt_i)
      FMT_I: begin
        inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode};
        err_o  = ~fits12;
      end
      FMT_S: begin
        inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode};
        err_o  = ~fits12;
      end
      FMT_B: begin
        inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode};
        err_o  = ~fits13 | imm_i[0];
      end
      FMT_J: begin
        inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode};
        err_o  = ~fits21 | imm_i[0];
      end
      FMT_U: begin
        inst_o = {imm_i[31:12], rd_i, opcode};
        err_o  = |imm_i[11:0];
      end
      default: begin
        inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode};
        err_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
// Purpose : Streaming RV32 instruction encoder. Two-stage valid/ready
//           pipeline: stage 1 captures the field bundle and its format,
//           imm_pack builds the word, stage 2 holds the word for the sink.
//           Saturating counters track emitted words and erroneous words.
// Config  : define INST_ENCODER_ROUNDTRIP_CHECK_EN to add the rt_mismatch
//           port, which re-decodes the emitted immediate and flags any
//           disagreement with the original (never expected to fire).
// Ports   : clk, rstn (async active-low)
//           in_valid/in_ready + in_op5, in_rd, in_rs1, in_rs2, in_funct3,
//           in_funct7, in_imm           - field bundle input
//           out_valid/out_ready + out_inst, out_err - encoded word output
//           cnt_words, cnt_errs         - saturating statistics
//           rt_mismatch                 - round-trip check (optional)
// ---------------------------------------------------------------------------
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op5,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
  output logic             rt_mismatch,
`endif
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_errs
);

  logic             s1_valid_q, s1_valid_d;
  fmt_e             s1_fmt_q;
  logic [4:0]       s1_op5_q, s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]       s1_f3_q;
  logic [6:0]       s1_f7_q;
  logic [31:0]      s1_imm_q;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_inst_q;
  logic             s2_err_q;

  logic [CNT_W-1:0] cnt_words_q, cnt_words_d;
  logic [CNT_W-1:0] cnt_errs_q, cnt_errs_d;

  logic [31:0]      pack_inst;
  logic             pack_err;

  logic             s2_load;
  logic             s1_load;
  logic             out_hs;

  // Stage 2 takes stage 1 whenever it is empty or draining this cycle;
  // stage 1 in turn frees up when its content moves on. No skid buffer,
  // so in_ready follows out_ready combinationally.
  assign out_hs   = s2_valid_q & out_ready;
  assign s2_load  = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign s1_load  = in_valid & in_ready;

  imm_pack u_imm_pack (
    .fmt_i    (s1_fmt_q),
    .op5_i    (s1_op5_q),
    .rd_i     (s1_rd_q),
    .rs1_i    (s1_rs1_q),
    .rs2_i    (s1_rs2_q),
    .funct3_i (s1_f3_q),
    .funct7_i (s1_f7_q),
    .imm_i    (s1_imm_q),
    .inst_o   (pack_inst),
    .err_o    (pack_err)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    cnt_words_d = cnt_words_q;
    cnt_errs_d  = cnt_errs_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s2_load)  s2_valid_d = s1_valid_q;
    if (out_hs && (cnt_words_q != '1)) cnt_words_d = cnt_words_q + CNT_W'(1);
    if (out_hs && s2_err_q && (cnt_errs_q != '1)) cnt_errs_d = cnt_errs_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= FMT_R;
      s1_op5_q    <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_f3_q     <= '0;
      s1_f7_q     <= '0;
      s1_imm_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_inst_q   <= '0;
      s2_err_q    <= 1'b0;
      cnt_words_q <= '0;
      cnt_errs_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      cnt_words_q <= cnt_words_d;
      cnt_errs_q  <= cnt_errs_d;
      if (s1_load) begin
        s1_fmt_q <= op5_to_fmt(in_op5);
        s1_op5_q <= in_op5;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_f3_q  <= in_funct3;
        s1_f7_q  <= in_funct7;
        s1_imm_q <= in_imm;
      end
      // Word and error only change when a new word enters, so they stay
      // stable while the sink stalls.
      if (s2_load && s1_valid_q) begin
        s2_inst_q <= pack_inst;
        s2_err_q  <= pack_err;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign cnt_words = cnt_words_q;
  assign cnt_errs  = cnt_errs_q;

`ifdef INST_ENCODER_ROUNDTRIP_CHECK_EN
  fmt_e        s2_fmt_q;
  logic [31:0] s2_imm_q;
  logic [31:0] rt_imm;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_fmt_q <= FMT_R;
      s2_imm_q <= '0;
    end else if (s2_load && s1_valid_q) begin
      s2_fmt_q <= s1_fmt_q;
      s2_imm_q <= s1_imm_q;
    end
  end

  // Same extraction the decode stage's immediate generator performs.
  always_comb begin
    rt_imm = '0;
    case (s2_fmt_q)
      FMT_I:   rt_imm = {{20{s2_inst_q[31]}}, s2_inst_q[31:20]};
      FMT_S:   rt_imm = {{20{s2_inst_q[31]}}, s2_inst_q[31:25], s2_inst_q[11:7]};
      FMT_B:   rt_imm = {{19{s2_inst_q[31]}}, s2_inst_q[31], s2_inst_q[7],
                         s2_inst_q[30:25], s2_inst_q[11:8], 1'b0};
      FMT_J:   rt_imm = {{11{s2_inst_q[31]}}, s2_inst_q[31], s2_inst_q[19:12],
                         s2_inst_q[20], s2_inst_q[30:21], 1'b0};
      FMT_U:   rt_imm = {s2_inst_q[31:12], 12'b0};
      default: rt_imm = s2_imm_q;
    endcase
  end

  assign rt_mismatch = s2_valid_q & ~s2_err_q & (s2_fmt_q != FMT_R) & (rt_imm != s2_imm_q);

  rt_never_mismatch : assert property (@(posedge clk) disable iff (!rstn) !rt_mismatch);
`endif

endmodule
